fetch_unit: RTL and testbench

Instruction fetch front end that consumes the program counter stream. It issues sequential word fetches to instruction memory over a valid/ready request channel and collects in-order responses into a small buffer. It presents (pc, instruction) pairs to decode with a valid/ready handshake. A redirect from the branch/jump resolution stage restarts fetch at a new target, and any responses already in flight for the old path are discarded.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit,
// buffers in-order responses as {pc, instr} and discards in-flight responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic          req_fire, push, pop;
  logic [31:0]   redirect_tgt;
  logic [CW:0]   credit_used;

  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  // Buffered entries count against credit so every response has a guaranteed slot.
  assign credit_used    = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = req_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid = (cnt_q != '0) && !redirect_valid;
  assign if_pc    = pc_mem_q[rd_ptr_q];
  assign if_instr = instr_mem_q[rd_ptr_q];
  assign pop      = if_valid && if_ready;
  assign push     = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  always_comb begin
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    out_d    = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    if (req_fire) req_pc_d = req_pc_q + 32'd4;
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    // Everything still unanswered after this cycle belongs to the old path.
    if (redirect_valid) begin
      req_pc_d = redirect_tgt;
      rsp_pc_d = redirect_tgt;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      drop_d   = out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the presented pc/instr read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (cnt_q == DEPTH_C)))
        else $error("fetch_unit: buffer overflow");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural in-order memory with programmable latency,
// immediate-assertion checks on reset, streaming, backpressure, redirects, wrap and mid-run reset.
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_pass  = 0;
  int n_total = 0;
  int lat     = 1;
  int acc_cnt;
  int cyc;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  // In-order memory: a request accepted at edge k answers in the cycle sampled at edge k+lat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
      acc_cnt        <= 0;
      cyc            <= 0;
    end else begin
      cyc <= cyc + 1;
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + lat - 1);
        acc_cnt <= acc_cnt + 1;
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= q_addr[0] ^ KEY;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Waits for the next presented instruction (if_ready assumed high) and checks it.
  task automatic expect_instr(input string tag, input logic [31:0] pc);
    for (int i = 0; i < 20; i++) begin
      if (if_valid) begin
        $display("decode %s: pc=%08h instr=%08h", tag, if_pc, if_instr);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instr, pc ^ KEY);
        step();
        return;
      end
      step();
    end
    chk({tag, "_timeout"}, 32'(if_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    lat            = 1;

    // Reset values
    step(); step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr",  imem_req_addr,       32'h0);
    chk("rst_if_valid",  32'(if_valid),       32'd0);
    chk("rst_if_pc",     if_pc,               32'h0);
    chk("rst_if_instr",  if_instr,            32'h0);

    // Free run, 1-cycle memory
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr",  imem_req_addr,       32'h0);
    expect_instr("run0", 32'h0);
    expect_instr("run1", 32'h4);
    expect_instr("run2", 32'h8);
    expect_instr("run3", 32'hC);

    // Backpressure: only DEPTH requests issued
    rst = 1'b1; step(); step();
    if_ready = 1'b0;
    rst = 1'b0;
    repeat (10) step();
    $display("stall: accepted=%0d req_valid=%0b if_pc=%08h", acc_cnt, imem_req_valid, if_pc);
    chk("stall_accepts",   32'(acc_cnt),        32'd2);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_if_valid",  32'(if_valid),       32'd1);
    chk("stall_if_pc",     if_pc,               32'h0);
    if_ready = 1'b1;
    expect_instr("stall0", 32'h0);
    expect_instr("stall1", 32'h4);
    expect_instr("stall2", 32'h8);

    // Redirect with two requests outstanding on a 3-cycle memory
    rst = 1'b1; step(); step();
    lat = 3; if_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10 && acc_cnt != 2; i++) step();
    chk("out2_accepts", 32'(acc_cnt), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("redir_if_valid",  32'(if_valid),       32'd0);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0; if_ready = 1'b1;
    expect_instr("drop0", 32'h100);
    expect_instr("drop1", 32'h104);

    // Redirect coinciding with a response, unaligned target
    rst = 1'b1; step(); step();
    lat = 1; if_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10 && !(if_valid && imem_rsp_valid); i++) step();
    chk("coinc_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    #1;
    chk("coinc_if_valid",  32'(if_valid),       32'd0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coinc_next_req_addr",  imem_req_addr,       32'h200);
    if_ready = 1'b1;
    expect_instr("coinc0", 32'h200);
    expect_instr("coinc1", 32'h204);

    // Address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    expect_instr("wrap0", 32'hFFFF_FFF8);
    expect_instr("wrap1", 32'hFFFF_FFFC);
    expect_instr("wrap2", 32'h0000_0000);

    // Reset mid-operation with responses pending
    if_ready = 1'b0; lat = 3;
    repeat (6) step();
    chk("pre_rst_if_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    #1;
    $display("midrst: req_valid=%0b if_valid=%0b if_pc=%08h if_instr=%08h",
             imem_req_valid, if_valid, if_pc, if_instr);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_req_addr",  imem_req_addr,       32'h0);
    chk("midrst_if_valid",  32'(if_valid),       32'd0);
    chk("midrst_if_pc",     if_pc,               32'h0);
    chk("midrst_if_instr",  if_instr,            32'h0);
    step(); step();
    lat = 1;
    rst = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr",  imem_req_addr,       32'h0);
    chk("post_rst_if_valid",  32'(if_valid),       32'd0);
    if_ready = 1'b1;
    expect_instr("postrst0", 32'h0);
    expect_instr("postrst1", 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
